// File: rtl/mul_err_pkg.sv
// rtl/mul_err_pkg.sv - shared state type and sizing constants for the multiplier error sweep
package mul_err_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int DEF_IN_W  = 2;
    localparam int DEF_OUT_W = 4;
    localparam int DEF_ET    = 4;

    localparam int VEC_W = 2 * DEF_IN_W;
    localparam int NVEC  = 1 << VEC_W;
    localparam int SUM_W = DEF_OUT_W + VEC_W;
    localparam int CNT_W = VEC_W + 1;

endpackage

// File: rtl/mul_err_calc.sv
// rtl/mul_err_calc.sv - exact product and absolute error of one approximate multiplier sample
module mul_err_calc #(
    parameter int IN_W  = 2,
    parameter int OUT_W = 4
) (
    input  logic [2*IN_W-1:0] vec_i,
    input  logic [OUT_W-1:0]  approx_i,
    output logic [OUT_W-1:0]  abs_err_o
);

    logic [IN_W-1:0]       a;
    logic [IN_W-1:0]       b;
    logic [2*IN_W-1:0]     prod;
    logic [OUT_W-1:0]      exact;
    logic signed [OUT_W:0] diff;

    assign a     = vec_i[IN_W-1:0];
    assign b     = vec_i[2*IN_W-1:IN_W];
    assign prod  = (2*IN_W)'(a) * (2*IN_W)'(b);
    assign exact = OUT_W'(prod);

    // One extra bit keeps the signed difference from wrapping before the magnitude is taken.
    assign diff      = $signed({1'b0, exact}) - $signed({1'b0, approx_i});
    assign abs_err_o = diff[OUT_W] ? OUT_W'(-diff) : OUT_W'(diff);

endmodule

// File: rtl/mul_err_sweep.sv
// rtl/mul_err_sweep.sv - exhaustive sweep of an approximate multiplier with error statistics
module mul_err_sweep
    import mul_err_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int ET    = DEF_ET
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic [2*IN_W-1:0]      vec_o,
    input  logic [OUT_W-1:0]       approx_p,
    output logic                   busy,
    output logic                   done,
    output logic [OUT_W-1:0]       max_err,
    output logic [2*IN_W-1:0]      wc_vec,
    output logic [OUT_W+2*IN_W-1:0] sum_err,
    output logic [2*IN_W:0]        viol_cnt,
    output logic                   pass
);

    localparam int VW = 2 * IN_W;
    localparam int SW = OUT_W + VW;
    localparam int CW = VW + 1;
    localparam logic [OUT_W-1:0] ET_V = OUT_W'(ET);

    state_e          state_q, state_d;
    logic [VW-1:0]   cnt_q, cnt_d;
    logic            drain_q, drain_d;
    logic            clr;

    logic            s1_vld_q;
    logic [VW-1:0]   s1_vec_q;
    logic [OUT_W-1:0] s1_p_q;
    logic            s2_vld_q;
    logic [VW-1:0]   s2_vec_q;
    logic [OUT_W-1:0] s2_err_q;
    logic [OUT_W-1:0] s2_err_d;

    logic [OUT_W-1:0] max_err_q;
    logic [VW-1:0]    wc_vec_q;
    logic [SW-1:0]    sum_q;
    logic [CW-1:0]    viol_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        clr     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                    clr     = 1'b1;
                end
            end
            SWEEP: begin
                cnt_d = cnt_q + VW'(1);
                if (&cnt_q) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end
            end
            DRAIN: begin
                // Two cycles let the last vector clear S2 and S3.
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = DONE;
                    drain_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign vec_o = (state_q == SWEEP) ? cnt_q : '0;
    assign busy  = (state_q == SWEEP) || (state_q == DRAIN);
    assign done  = (state_q == DONE);

    mul_err_calc #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_calc (
        .vec_i     (s1_vec_q),
        .approx_i  (s1_p_q),
        .abs_err_o (s2_err_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_vec_q <= '0;
            s1_p_q   <= '0;
            s2_vld_q <= 1'b0;
            s2_vec_q <= '0;
            s2_err_q <= '0;
        end else begin
            s1_vld_q <= (state_q == SWEEP);
            s1_vec_q <= vec_o;
            s1_p_q   <= approx_p;
            s2_vld_q <= s1_vld_q;
            s2_vec_q <= s1_vec_q;
            s2_err_q <= s2_err_d;
        end
    end

    // Strict compare on max keeps the earliest vector on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_err_q <= '0;
            wc_vec_q  <= '0;
            sum_q     <= '0;
            viol_q    <= '0;
        end else if (clr) begin
            max_err_q <= '0;
            wc_vec_q  <= '0;
            sum_q     <= '0;
            viol_q    <= '0;
        end else if (s2_vld_q) begin
            sum_q <= sum_q + SW'(s2_err_q);
            if (s2_err_q > ET_V) begin
                viol_q <= viol_q + CW'(1);
            end
            if (s2_err_q > max_err_q) begin
                max_err_q <= s2_err_q;
                wc_vec_q  <= s2_vec_q;
            end
        end
    end

    assign max_err  = max_err_q;
    assign wc_vec   = wc_vec_q;
    assign sum_err  = sum_q;
    assign viol_cnt = viol_q;
    assign pass     = done && (max_err_q <= ET_V);

endmodule

// File: tb/tb_mul_err_sweep.sv
// tb/tb_mul_err_sweep.sv - self-checking bench for mul_err_sweep
module tb_mul_err_sweep;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] vec_o;
    logic [3:0] approx_p;
    logic       busy;
    logic       done;
    logic [3:0] max_err;
    logic [3:0] wc_vec;
    logic [7:0] sum_err;
    logic [4:0] viol_cnt;
    logic       pass;

    logic [3:0] lut [16];
    int cmp_cnt = 0;
    int mis_cnt = 0;

    typedef struct {
        string name;
        int    mode;
        int    max_e;
        int    wc_e;
        int    sum_e;
        int    viol_e;
        int    pass_e;
    } vec_t;

    vec_t tbl [4];

    always #5 clk = ~clk;

    assign approx_p = lut[vec_o];

    mul_err_sweep #(.IN_W(2), .OUT_W(4), .ET(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .vec_o    (vec_o),
        .approx_p (approx_p),
        .busy     (busy),
        .done     (done),
        .max_err  (max_err),
        .wc_vec   (wc_vec),
        .sum_err  (sum_err),
        .viol_cnt (viol_cnt),
        .pass     (pass)
    );

    task automatic chk(input string name, input int act, input int exp);
        cmp_cnt++;
        if (act != exp) begin
            mis_cnt++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // 0 exact, 1 tied low, 2 tied high, 3 exact plus one
    task automatic fill_lut(input int mode);
        for (int v = 0; v < 16; v++) begin
            int a, b;
            a = v % 4;
            b = v / 4;
            case (mode)
                0: lut[v] = 4'(a * b);
                1: lut[v] = 4'd0;
                2: lut[v] = 4'd15;
                default: lut[v] = 4'(a * b + 1);
            endcase
        end
    endtask

    task automatic model(output int mx, output int wc, output int sm, output int vc);
        mx = 0; wc = 0; sm = 0; vc = 0;
        for (int v = 0; v < 16; v++) begin
            int e;
            e = (v % 4) * (v / 4) - int'(lut[v]);
            if (e < 0) e = -e;
            if (e > mx) begin
                mx = e;
                wc = v;
            end
            sm += e;
            if (e > 4) vc++;
        end
    endtask

    task automatic run_sweep(input string tag, input int pulse_at);
        int done_cyc;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_clr_max"}, max_err, 0);
        chk({tag, "_clr_sum"}, sum_err, 0);
        chk({tag, "_clr_viol"}, viol_cnt, 0);
        chk({tag, "_busy_e0"}, busy, 1);
        done_cyc = -1;
        for (int c = 1; c <= 40; c++) begin
            if (c == pulse_at) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        chk({tag, "_done_cycle"}, done_cyc, 18);
        chk({tag, "_busy_done"}, busy, 0);
    endtask

    task automatic check_stats(input string tag, input int mx, input int wc,
                               input int sm, input int vc, input int ps);
        chk({tag, "_max_err"}, max_err, mx);
        chk({tag, "_wc_vec"}, wc_vec, wc);
        chk({tag, "_sum_err"}, sum_err, sm);
        chk({tag, "_viol_cnt"}, viol_cnt, vc);
        chk({tag, "_pass"}, pass, ps);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_vec_o"}, vec_o, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        check_stats(tag, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int mx, wc, sm, vc;

        tbl[0] = '{"exact", 0, 0, 0, 0, 0, 1};
        tbl[1] = '{"tied0", 1, 9, 15, 36, 3, 0};
        tbl[2] = '{"tiedF", 2, 15, 0, 204, 16, 0};
        tbl[3] = '{"plus1", 3, 1, 0, 16, 0, 1};

        fill_lut(0);
        #23;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("idle");

        for (int i = 0; i < 4; i++) begin
            fill_lut(tbl[i].mode);
            run_sweep(tbl[i].name, -1);
            check_stats(tbl[i].name, tbl[i].max_e, tbl[i].wc_e, tbl[i].sum_e,
                        tbl[i].viol_e, tbl[i].pass_e);
        end

        for (int r = 0; r < 6; r++) begin
            for (int v = 0; v < 16; v++) lut[v] = 4'($urandom_range(0, 15));
            model(mx, wc, sm, vc);
            run_sweep("rand", -1);
            check_stats("rand", mx, wc, sm, vc, (mx <= 4) ? 1 : 0);
        end

        // Extra start mid-sweep must not restart or add samples.
        fill_lut(3);
        run_sweep("restart_ign", 5);
        check_stats("restart_ign", 1, 0, 16, 0, 1);

        // Asynchronous abort part way through a sweep.
        fill_lut(1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_all_zero("post_abort");
        run_sweep("after_abort", -1);
        check_stats("after_abort", 9, 15, 36, 3, 0);

        // From DONE with nonzero stats back to an exact multiplier.
        fill_lut(0);
        run_sweep("from_done", -1);
        check_stats("from_done", 0, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end

endmodule

// File: doc/mul_err_sweep.md
# mul_err_sweep

Exhaustive error-evaluation harness for the 4-input/4-output approximate 2x2 multiplier netlists. It drives every input vector into the approximate circuit, captures the product that comes back, and compares it against the exact product. It accumulates worst-case error, total absolute error and error-threshold violations, then flags pass/fail. The multiplier sits combinationally between this block's `vec_o` and `approx_p` ports, so the block is both its upstream stimulus stage and its downstream checking stage.

## Interface
- `IN_W`, 2: operand width; vector width is `2*IN_W`.
- `OUT_W`, 4: product width.
- `ET`, 4: error threshold; a sample violates when abs error > `ET`.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: begin a sweep; sampled only in IDLE or DONE.
- `vec_o` output 2*IN_W: stimulus to the multiplier. Bit k drives `in<k>`. Operand a = `vec_o[IN_W-1:0]`, b = `vec_o[2*IN_W-1:IN_W]`.
- `approx_p` input OUT_W: multiplier product, bit k from `out<k>`. Combinational response to `vec_o` within the same cycle.
- `busy` output 1: high in SWEEP and DRAIN.
- `done` output 1: high in DONE.
- `max_err` output OUT_W: largest abs error.
- `wc_vec` output 2*IN_W: first vector reaching `max_err`.
- `sum_err` output OUT_W+2*IN_W: sum of abs errors.
- `viol_cnt` output 2*IN_W+1: number of violating vectors.
- `pass` output 1: `done && max_err <= ET`.

## Operation
- Clock and reset:
  - One clock `clk`.
  - Reset is asynchronous and active-low (`rst_n`).
  - Reset clears every register and output to 0; state becomes IDLE.
- States:
  - IDLE: on `start`, clear stats, go to SWEEP.
  - SWEEP: vector counter steps 0 to 2^(2*IN_W)-1, one vector per cycle. After the last vector, go to DRAIN.
  - DRAIN: 2 cycles while the pipeline empties, then go to DONE.
  - DONE: results held. On `start`, clear stats and go to SWEEP.
- `start` in SWEEP or DRAIN is ignored.
- `vec_o` holds 0 outside SWEEP.
- Three-stage pipeline:
  - S1 registers `vec_o` and `approx_p` together with a valid bit.
  - S2 computes exact = a*b at OUT_W bits, and abs error = |exact − approx| using OUT_W+1-bit signed subtraction, magnitude truncated to OUT_W bits.
  - S3 accumulates into the stats.
- S3 update rules:
  - `sum_err` adds the error; it cannot overflow at the default sizing.
  - `viol_cnt` increments when the error > `ET`.
  - `max_err`/`wc_vec` update only when the error is strictly greater, so on ties the earliest vector wins.
- Clearing statistics and the first S1 capture never coincide, so no simultaneous clear/accumulate case exists.

## Timing
- Edge E0 samples `start`; state is SWEEP after E0. `vec_o` = k during the cycle after edge Ek.
- S1 captures vector k at E(k+1).
- S3 accumulates vector k at E(k+3).
- After the last accumulate (E18 at default sizing) the state is DONE: `done`=1, `busy`=0. That is 18 cycles from the start edge to `done`.
- Stats are updated only by registers; outputs are glitch-free.
- `rst_n` low mid-sweep aborts immediately: all outputs read 0. The next sweep needs a fresh `start`.

## Structure
- Shared package `mul_err_pkg`:
  - state enum {IDLE, SWEEP, DRAIN, DONE};
  - width helper constants: `VEC_W`, `NVEC`, `SUM_W`, `CNT_W`.
- One sub-module, `mul_err_calc`:
  - holds the S2 combinational exact-product and abs-error logic;
  - parameterised by `IN_W`/`OUT_W` for reuse with larger multipliers.
- Top level holds the FSM, vector counter, pipeline registers and accumulators.

## Test plan
- Exact multiplier looped back (`approx_p` = a*b):
  - `done` at start+18;
  - `max_err`=0, `sum_err`=0, `viol_cnt`=0, `pass`=1.
- `approx_p` tied 0:
  - `max_err`=9, `wc_vec`=0xF;
  - `sum_err`=36, `viol_cnt`=3;
  - `pass`=0.
- `approx_p` tied 0xF:
  - `max_err`=15, `wc_vec`=0x0;
  - `sum_err`=204, `viol_cnt`=16;
  - `pass`=0.
- Pulse `start` again during SWEEP (exact loopback):
  - ignored; `done` still at start+18;
  - exactly 16 samples accumulated.
- Drop `rst_n` at start+8 with `approx_p` tied 0:
  - all outputs 0, state IDLE.
  - A new `start` yields the full 0-tied results above.
- From DONE (0-tied results), reconnect the exact loopback and pulse `start`:
  - stats clear the next cycle;
  - final `max_err`=0, `pass`=1.
